// File: rtl/bus2st_lane_sched_if.sv
// Memory read port and bus2st lane bundle for the lane scheduler.
// master is the scheduler side; slave is the memory/lane side.
interface bus2st_lane_sched_if #(
  parameter int BUS       = 534,
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = 32
);
  logic                 mem_rd_req;
  logic [ADDR_W-1:0]    mem_rd_addr;
  logic                 mem_rd_ack;
  logic                 rsp_valid;
  logic [BUS-1:0]       rsp_data;
  logic [NUM_LANES-1:0] lane_bus_ready;
  logic [BUS-1:0]       lane_bus_data;
  logic [NUM_LANES-1:0] lane_bus_en;

  modport master (
    output mem_rd_req, mem_rd_addr,
    output lane_bus_data, lane_bus_en,
    input  mem_rd_ack, rsp_valid, rsp_data,
    input  lane_bus_ready
  );

  modport slave (
    input  mem_rd_req, mem_rd_addr,
    input  lane_bus_data, lane_bus_en,
    output mem_rd_ack, rsp_valid, rsp_data,
    output lane_bus_ready
  );
endinterface

// File: rtl/bus2st_lane_sched.sv
// Fetches turbo packets from memory and hands each whole packet
// to one ready bus2st lane, round-robin, with bounded outstanding reads.
module bus2st_lane_sched #(
  parameter int BUS                   = 534,
  parameter int NUM_LANES             = 4,
  parameter int NUM_BUS_PER_TURBO_PKT = 25,
  parameter int ADDR_W                = 32,
  parameter int ADDR_STEP             = 1,
  parameter int MAX_OUTST             = 8,
  parameter int PICK_GAP              = 3
) (
  input  logic              clk_400,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_pkts,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       pkt_cnt,
  bus2st_lane_sched_if.master io
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [7:0] NPKT = 8'(NUM_BUS_PER_TURBO_PKT);
  localparam logic [7:0] MO   = 8'(MAX_OUTST);
  localparam logic [7:0] GAPN = 8'(PICK_GAP);

  typedef enum logic [1:0] {IDLE, PICK, XFER, GAP} state_e;

  state_e               state_q, state_d;
  logic [LW-1:0]        grant_q, grant_d;
  logic [7:0]           issued_q, issued_d;
  logic [7:0]           rcvd_q, rcvd_d;
  logic [7:0]           gap_q, gap_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [15:0]          num_q, num_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 req_q, req_d;
  logic [BUS-1:0]       data_q, data_d;
  logic [NUM_LANES-1:0] en_q, en_d;

  logic          acc;
  logic          found;
  logic [LW-1:0] pick;
  logic [LW-1:0] idx;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    issued_d = issued_q;
    rcvd_d   = rcvd_q;
    gap_d    = gap_q;
    addr_d   = addr_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = err_q;
    req_d    = 1'b0;
    data_d   = data_q;
    en_d     = '0;
    acc      = req_q && io.mem_rd_ack;
    found    = 1'b0;
    pick     = grant_q;
    idx      = '0;

    // Round-robin search starting just after the last grant.
    for (int i = 1; i <= NUM_LANES; i++) begin
      idx = LW'((int'(grant_q) + i) % NUM_LANES);
      if (!found && io.lane_bus_ready[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    if (acc) begin
      addr_d   = addr_q + ADDR_W'(ADDR_STEP);
      issued_d = issued_q + 8'd1;
    end

    if (io.rsp_valid) begin
      if (state_q == XFER && rcvd_q < NPKT) begin
        rcvd_d        = rcvd_q + 8'd1;
        data_d        = io.rsp_data;
        en_d[grant_q] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base_addr;
          num_d  = num_pkts;
          cnt_d  = '0;
          err_d  = io.rsp_valid;
          if (num_pkts == 16'd0) done_d = 1'b1;
          else state_d = PICK;
        end
      end
      PICK: begin
        if (found) begin
          grant_d  = pick;
          issued_d = '0;
          rcvd_d   = '0;
          state_d  = XFER;
        end
      end
      XFER: begin
        if (!io.lane_bus_ready[grant_q] && rcvd_q < NPKT)
          err_d = 1'b1;
        if (rcvd_d == NPKT) begin
          cnt_d = cnt_q + 16'd1;
          gap_d = '0;
          if (cnt_q + 16'd1 == num_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else begin
          req_d = (issued_d < NPKT) && (8'(issued_d - rcvd_d) < MO);
        end
      end
      GAP: begin
        // Give the filled lane time to drop bus_ready.
        if (gap_q + 8'd1 >= GAPN) state_d = PICK;
        else gap_d = gap_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_400) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= LW'(NUM_LANES - 1);
      issued_q <= '0;
      rcvd_q   <= '0;
      gap_q    <= '0;
      addr_q   <= '0;
      num_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      data_q   <= '0;
      en_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      issued_q <= issued_d;
      rcvd_q   <= rcvd_d;
      gap_q    <= gap_d;
      addr_q   <= addr_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      req_q    <= req_d;
      data_q   <= data_d;
      en_q     <= en_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign err            = err_q;
  assign pkt_cnt        = cnt_q;
  assign io.mem_rd_req  = req_q;
  assign io.mem_rd_addr = addr_q;
  assign io.lane_bus_data = data_q;
  assign io.lane_bus_en = en_q;
endmodule

// File: tb/tb_bus2st_lane_sched.sv
// Bench for bus2st_lane_sched: memory responder, lane write scoreboard
// and round-robin lane model driven by directed and random jobs.
module tb_bus2st_lane_sched;
  localparam int BUS = 534;
  localparam int NL  = 4;
  localparam int NP  = 25;
  localparam int AW  = 32;
  localparam int MO  = 8;

  logic          clk_400 = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   num_pkts = '0;
  logic          busy, done, err;
  logic [15:0]   pkt_cnt;

  bus2st_lane_sched_if #(.BUS(BUS), .NUM_LANES(NL), .ADDR_W(AW)) io ();

  bus2st_lane_sched dut (
    .clk_400  (clk_400),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .num_pkts (num_pkts),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .pkt_cnt  (pkt_cnt),
    .io       (io)
  );

  always #5 clk_400 = ~clk_400;

  typedef struct {
    logic [BUS-1:0] d;
    int             due;
  } pend_t;

  typedef struct {
    logic [NL-1:0]  en;
    logic [BUS-1:0] d;
    int             c;
  } wr_t;

  pend_t         pend[$];
  wr_t           exp_wr[$];
  int            lane_q[$];
  int            last_lane = NL - 1;
  logic [AW-1:0] exp_addr = '0;

  int n_tot = 0, n_pass = 0, cyc = 0;
  int n_acc = 0, n_rsp = 0, n_wr = 0, n_done = 0, wi = 0;
  int ack_mode = 1, lat_min = 4, lat_max = 4, last_rsp_cyc = 0;
  bit hold = 0, spur = 0, live = 1, rsp_this = 0;

  task automatic chk(input string tag, input logic [BUS-1:0] obs,
                     input logic [BUS-1:0] exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BUS-1:0] rnd();
    logic [543:0] t;
    for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
    return t[BUS-1:0];
  endfunction

  function automatic int rr_pick(input logic [NL-1:0] mask);
    for (int k = 1; k <= NL; k++) begin
      int l;
      l = (last_lane + k) % NL;
      if (mask[l]) begin
        last_lane = l;
        return l;
      end
    end
    return last_lane;
  endfunction

  // Memory responder and lane-write scoreboard.
  initial begin
    pend_t p;
    wr_t   w;
    io.rsp_valid  = 1'b0;
    io.rsp_data   = '0;
    io.mem_rd_ack = 1'b1;
    forever begin
      @(negedge clk_400);
      if (io.mem_rd_req && io.mem_rd_ack) begin
        chk("rd_addr", BUS'(io.mem_rd_addr), BUS'(exp_addr));
        chk("outst", BUS'(n_acc - (n_rsp - int'(rsp_this)) < MO), BUS'(1));
        exp_addr = exp_addr + 1'b1;
        n_acc++;
        pend.push_back('{d: rnd(), due: cyc + int'($urandom_range(lat_min, lat_max))});
      end
      if (exp_wr.size() != 0 && exp_wr[0].c + 1 == cyc) begin
        w = exp_wr.pop_front();
        chk("lane_en", BUS'(io.lane_bus_en), BUS'(w.en));
        chk("lane_data", io.lane_bus_data, w.d);
      end else begin
        chk("no_en", BUS'(io.lane_bus_en), BUS'(0));
      end
      if (io.lane_bus_en != '0) n_wr++;
      if (done) n_done++;

      @(posedge clk_400);
      #2;
      cyc++;
      rsp_this = 0;
      io.rsp_valid = 1'b0;
      if (spur) begin
        io.rsp_valid = 1'b1;
        io.rsp_data  = rnd();
        spur = 0;
      end else if (!hold && pend.size() != 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        io.rsp_valid = 1'b1;
        io.rsp_data  = p.d;
        rsp_this = 1;
        n_rsp++;
        last_rsp_cyc = cyc;
        if (live) begin
          exp_wr.push_back('{en: NL'(1) << lane_q[wi / NP], d: p.d, c: cyc});
          wi++;
        end
      end
      io.mem_rd_ack = (ack_mode == 2) ? ($urandom_range(0, 1) == 1)
                                      : (ack_mode == 1);
    end
  end

  task automatic drive_edge();
    @(posedge clk_400);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input int np,
                          input logic [NL-1:0] mask);
    drive_edge();
    start = 1'b1;
    base_addr = b;
    num_pkts = 16'(np);
    exp_addr = b;
    wi = 0;
    lane_q.delete();
    for (int i = 0; i < np; i++) lane_q.push_back(rr_pick(mask));
    drive_edge();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_400);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk(tag, BUS'(got), BUS'(1));
  endtask

  task automatic finish_job(input string tag, input int np,
                            input int a0, input int d0);
    chk({tag, "_done_lat"}, BUS'(cyc), BUS'(last_rsp_cyc + 1));
    chk({tag, "_pkt_cnt"}, BUS'(pkt_cnt), BUS'(np));
    chk({tag, "_err"}, BUS'(err), BUS'(0));
    repeat (3) @(negedge clk_400);
    chk({tag, "_idle"}, BUS'(busy), BUS'(0));
    chk({tag, "_reqs"}, BUS'(n_acc - a0), BUS'(np * NP));
    chk({tag, "_one_done"}, BUS'(n_done - d0), BUS'(1));
    chk({tag, "_wr_left"}, BUS'(exp_wr.size()), BUS'(0));
  endtask

  task automatic run_job(input string tag, input logic [AW-1:0] b,
                         input int np);
    int a0, d0;
    a0 = n_acc;
    d0 = n_done;
    do_start(b, np, 4'hF);
    wait_done({tag, "_done"}, 4000);
    finish_job(tag, np, a0, d0);
  endtask

  initial begin
    int a0, d0, w0, left;
    bit got;
    logic [AW-1:0] a;

    io.lane_bus_ready = 4'hF;
    repeat (3) @(negedge clk_400);
    chk("reset_out", BUS'({busy, done, err, pkt_cnt, io.mem_rd_req,
        io.lane_bus_en, |io.lane_bus_data, |io.mem_rd_addr}), BUS'(0));
    drive_edge();
    rst_n = 1'b1;

    run_job("single", 32'h100, 1);

    a0 = n_acc;
    d0 = n_done;
    do_start(32'h100, 6, 4'hF);
    repeat (30) @(negedge clk_400);
    drive_edge();
    start = 1'b1;
    base_addr = 32'hDEAD_0000;
    num_pkts = 16'd1;
    drive_edge();
    start = 1'b0;
    chk("ign_busy", BUS'(busy), BUS'(1));
    wait_done("rr_done", 4000);
    finish_job("rr", 6, a0, d0);

    a0 = n_acc;
    drive_edge();
    start = 1'b1;
    base_addr = 32'h200;
    num_pkts = 16'd0;
    @(negedge clk_400);
    chk("zero_pre", BUS'(done), BUS'(0));
    drive_edge();
    start = 1'b0;
    @(negedge clk_400);
    chk("zero_done", BUS'({done, busy, pkt_cnt}), BUS'({1'b1, 1'b0, 16'd0}));
    @(negedge clk_400);
    chk("zero_once", BUS'(done), BUS'(0));
    chk("zero_noreq", BUS'(n_acc - a0), BUS'(0));

    ack_mode = 0;
    a0 = n_acc;
    d0 = n_done;
    do_start(32'h300, 1, 4'hF);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_400);
      if (io.mem_rd_req) begin
        got = 1;
        break;
      end
    end
    chk("bp_req", BUS'(got), BUS'(1));
    a = io.mem_rd_addr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_400);
      chk("bp_hold", BUS'({io.mem_rd_req, io.mem_rd_addr}), BUS'({1'b1, a}));
    end
    ack_mode = 1;
    wait_done("bp_done", 4000);
    finish_job("bp", 1, a0, d0);

    hold = 1;
    a0 = n_acc;
    d0 = n_done;
    do_start(32'h400, 1, 4'hF);
    repeat (50) @(negedge clk_400);
    chk("outst_cnt", BUS'(n_acc - a0), BUS'(MO));
    chk("outst_req", BUS'(io.mem_rd_req), BUS'(0));
    hold = 0;
    wait_done("outst_done", 4000);
    finish_job("outst", 1, a0, d0);

    io.lane_bus_ready = 4'b0100;
    a0 = n_acc;
    d0 = n_done;
    w0 = n_wr;
    do_start(32'h500, 2, 4'b0100);
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_400);
      if (n_wr - w0 >= NP) begin
        got = 1;
        break;
      end
    end
    chk("lane_first", BUS'(got), BUS'(1));
    drive_edge();
    io.lane_bus_ready = '0;
    repeat (20) @(negedge clk_400);
    chk("lane_wait", BUS'({busy, io.mem_rd_req}), BUS'(2'b10));
    chk("lane_wr_hold", BUS'(n_wr - w0), BUS'(NP));
    drive_edge();
    io.lane_bus_ready = 4'b0100;
    wait_done("lane_done", 4000);
    finish_job("lane", 2, a0, d0);
    io.lane_bus_ready = 4'hF;

    ack_mode = 2;
    lat_min = 1;
    lat_max = 6;
    for (int j = 0; j < 3; j++) begin
      int np;
      np = int'($urandom_range(1, 4));
      a = (j == 0) ? 32'hFFFF_FFF0 : AW'($urandom);
      run_job("rand", a, np);
    end
    ack_mode = 1;
    lat_min = 4;
    lat_max = 4;

    live = 0;
    drive_edge();
    spur = 1;
    repeat (3) @(negedge clk_400);
    chk("spur_err", BUS'({err, busy}), BUS'(2'b10));
    live = 1;

    w0 = n_wr;
    do_start(32'h600, 3, 4'hF);
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_400);
      if (n_wr - w0 >= 10) begin
        got = 1;
        break;
      end
    end
    chk("rst_mid", BUS'(got), BUS'(1));
    drive_edge();
    rst_n = 1'b0;
    hold = 1;
    last_lane = NL - 1;
    drive_edge();
    rst_n = 1'b1;
    hold = 0;
    live = 0;
    @(negedge clk_400);
    left = pend.size();
    chk("rst_out", BUS'({busy, done, err, pkt_cnt, io.mem_rd_req,
        io.lane_bus_en}), BUS'(0));
    for (int i = 0; i < 60 && pend.size() != 0; i++) @(negedge clk_400);
    repeat (2) @(negedge clk_400);
    chk("rst_left_err", BUS'(err), BUS'(left > 0));
    live = 1;
    run_job("after_rst", 32'h700, 2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/bus2st_lane_sched.md
Name: bus2st_lane_sched

Overview:
- Packet scheduler in the clk_400 domain between the host memory read port and NUM_LANES bus2st/TurboDecoder lanes.
- On start, fetches num_pkts turbo packets from consecutive memory addresses. Each packet is NUM_BUS_PER_TURBO_PKT bus words.
- Each whole packet goes to one lane whose bus_ready is high, with lanes chosen round-robin.
- Limits outstanding memory reads and reports completion and protocol errors.

Parameters:
- BUS, 534, width of one bus word.
- NUM_LANES, 4, number of bus2st lanes.
- NUM_BUS_PER_TURBO_PKT, 25, bus words per turbo packet.
- ADDR_W, 32, memory address width.
- ADDR_STEP, 1, address increment per bus word.
- MAX_OUTST, 8, maximum outstanding read requests (1..255).
- PICK_GAP, 3, idle cycles after a packet before lane_bus_ready is sampled again.

Ports:
- clk_400  in  1  400 MHz clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- base_addr  in  ADDR_W  first word address, latched on start.
- num_pkts  in  16  packet count, latched on start.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when the job completes.
- err  out  1  sticky; cleared only by reset or an accepted start.
- pkt_cnt  out  16  packets completed in the current job.
- mem_rd_req  out  1  read request valid.
- mem_rd_addr  out  ADDR_W  read address.
- mem_rd_ack  in  1  request accepted when mem_rd_req && mem_rd_ack.
- rsp_valid  in  1  read response valid; responses arrive in request order, no backpressure.
- rsp_data  in  BUS  read response data.
- lane_bus_ready  in  NUM_LANES  bus_ready from each bus2st lane.
- lane_bus_data  out  BUS  word broadcast to all lanes.
- lane_bus_en  out  NUM_LANES  one-hot write enable into the granted lane.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Internal values also reset: grant pointer = NUM_LANES-1 (so lane 0 is picked first), issued/received counters 0, gap counter 0.
- FSM states: IDLE, PICK, XFER, GAP.
- IDLE:
  - On start: latch base_addr and num_pkts, clear pkt_cnt and err.
  - If num_pkts==0, pulse done on the next cycle and stay in IDLE.
  - Otherwise go to PICK.
  - start outside IDLE is ignored.
- PICK:
  - Search lane_bus_ready from (grant+1) mod NUM_LANES upward, wrapping.
  - The first set bit becomes grant; clear issued and received counters; go to XFER.
  - If no bit is set, stay in PICK indefinitely.
- XFER, request side:
  - mem_rd_req=1 while issued<NUM_BUS_PER_TURBO_PKT and (issued-received)<MAX_OUTST.
  - mem_rd_addr comes from a running address register. It advances by ADDR_STEP on each accepted request, wraps modulo 2^ADDR_W, and carries across packets.
  - mem_rd_req is registered. Once it is asserted, it and the address hold until acked.
  - Deassertion only when the issue limit is hit.
- XFER, response side:
  - On rsp_valid, received increments.
  - One cycle later: lane_bus_data=rsp_data (registered) and lane_bus_en[grant]=1. Fixed latency is 1 cycle; other lane_bus_en bits stay 0.
  - A same-cycle accept and response updates both counters with no loss.
- XFER exit:
  - When received==NUM_BUS_PER_TURBO_PKT, increment pkt_cnt.
  - If pkt_cnt+1==num_pkts, go to IDLE with a done pulse on the next cycle. Otherwise go to GAP.
- GAP:
  - Wait PICK_GAP cycles, then go to PICK.
  - The gap lets the just-filled lane deassert bus_ready, since bus2st updates its counter a cycle after the final write.
- Errors:
  - rsp_valid outside XFER, or any rsp_valid once received==NUM_BUS_PER_TURBO_PKT: set err and drop the word, with no lane_bus_en.
  - lane_bus_ready[grant] falling during XFER before the last write: set err and continue the transfer.
- Reset mid-operation:
  - Go to IDLE immediately with all outputs 0.
  - Responses arriving afterwards are in-flight leftovers: they set err and are dropped.
- Widths:
  - issued and received counters are 8 bits; pkt_cnt is 16 bits; the outstanding difference is computed in 8 bits.

Test Plan:
- Single packet: start, base_addr=0x100, num_pkts=1, all lanes ready, ack always high, 4-cycle response latency -> 25 requests to 0x100..0x118; 25 lane_bus_en[0] pulses each 1 cycle after rsp_valid; done 1 cycle after the 25th response; pkt_cnt=1.
- Round-robin: num_pkts=6, all lanes ready -> packets go to lanes 0,1,2,3,0,1; addresses contiguous 0x100..0x195; done once; pkt_cnt=6.
- Lane availability: only lane 2 ready, num_pkts=2 -> first packet to lane 2; scheduler waits in PICK while lane 2's ready is low; second packet goes to lane 2 when ready returns.
- Outstanding limit: mem_rd_ack always high, rsp_valid withheld for 50 cycles -> exactly 8 requests accepted, then mem_rd_req low until responses return.
- Backpressure and edge cases: ack held low 10 cycles -> mem_rd_req and mem_rd_addr stable across them. num_pkts=0 -> done 1 cycle after start with no requests. start while busy -> ignored.
- Errors and reset: a spurious rsp_valid in IDLE -> err=1 and no lane_bus_en. Reset asserted mid-XFER -> next cycle all outputs 0 and state IDLE; a following start runs normally with err cleared.
